// File: rtl/pingpong_rally_ctrl_pkg.sv
// Shared types for the LED table-tennis rally controller.
//   state_e  : rally FSM states
//   player_e : player encoding (A=0, B=1), also used for server/winner
package pingpong_rally_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_SERVE  = 3'd0,
    ST_FLY_AB = 3'd1,
    ST_FLY_BA = 3'd2,
    ST_POINT  = 3'd3,
    ST_OVER   = 3'd4
  } state_e;

  typedef enum logic {
    PL_A = 1'b0,
    PL_B = 1'b1
  } player_e;

  function automatic player_e other(player_e p);
    return (p == PL_A) ? PL_B : PL_A;
  endfunction

endpackage

// File: rtl/pingpong_rally_ctrl_if.sv
// Player-button / display bus of the rally controller.
//   btn_a, btn_b        : player buttons (level, clk-synchronous)
//   led_q               : active-low one-hot ball, bit TRACK_LEN-1 = A end
//   score_a, score_b    : points
//   server              : 0 = A serves, 1 = B serves
//   point_a, point_b    : one-cycle point pulses
//   game_over, winner   : end-of-game flag and winner (0 = A, 1 = B)
// master = buttons/display side, slave = controller.
interface pingpong_rally_ctrl_if #(
  parameter int TRACK_LEN = 16,
  parameter int SCORE_W   = 4
);
  logic                 btn_a;
  logic                 btn_b;
  logic [TRACK_LEN-1:0] led_q;
  logic [SCORE_W-1:0]   score_a;
  logic [SCORE_W-1:0]   score_b;
  logic                 server;
  logic                 point_a;
  logic                 point_b;
  logic                 game_over;
  logic                 winner;

  modport master (
    output btn_a, btn_b,
    input  led_q, score_a, score_b, server, point_a, point_b, game_over, winner
  );

  modport slave (
    input  btn_a, btn_b,
    output led_q, score_a, score_b, server, point_a, point_b, game_over, winner
  );
endinterface

// File: rtl/pingpong_rally_ctrl_ball_track.sv
// Ball track: position counter (load/up/down), step prescaler and LED decode.
//   clk, reset  : clock, async active-low reset
//   run_i       : ball in flight, prescaler counts
//   clr_i       : restart the step period (ball returned)
//   load_i      : park ball at an end; load_end_i 0 = A end, 1 = B end
//   up_i, dn_i  : one step towards B / towards A
//   blank_i     : all LEDs off
//   pos_o       : ball position, 0 = A end
//   tick_o      : last cycle of a step period
//   led_o       : active-low one-hot ball
module pingpong_ball_track #(
  parameter int TRACK_LEN = 16,
  parameter int STEP_DIV  = 4,
  localparam int PW = $clog2(TRACK_LEN),
  localparam int CW = $clog2(STEP_DIV)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run_i,
  input  logic                 clr_i,
  input  logic                 load_i,
  input  logic                 load_end_i,
  input  logic                 up_i,
  input  logic                 dn_i,
  input  logic                 blank_i,
  output logic [PW-1:0]        pos_o,
  output logic                 tick_o,
  output logic [TRACK_LEN-1:0] led_o
);

  logic [PW-1:0] pos_q, pos_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = run_i && (cnt_q == CW'(STEP_DIV - 1));
  assign pos_o  = pos_q;

  // Prescaler sits at 0 outside flight so every serve starts a full period.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!run_i || clr_i || tick_o) cnt_d = '0;
  end

  always_comb begin
    pos_d = pos_q;
    if (load_i)    pos_d = load_end_i ? PW'(TRACK_LEN - 1) : '0;
    else if (up_i) pos_d = pos_q + 1'b1;
    else if (dn_i) pos_d = pos_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos_q <= '0;
      cnt_q <= '0;
    end else begin
      pos_q <= pos_d;
      cnt_q <= cnt_d;
    end
  end

  // Position 0 lights the MSB (A end).
  for (genvar i = 0; i < TRACK_LEN; i++) begin : g_led
    assign led_o[i] = blank_i | (pos_q != PW'(TRACK_LEN - 1 - i));
  end

endmodule

// File: rtl/pingpong_rally_ctrl.sv
// Rally/match controller for the two-player LED table-tennis game:
// serve, flight, hit windows, early-hit/miss faults, scoring, serve rotation,
// game end. Ball position and LED drive live in pingpong_ball_track.
//   clk, reset : clock, async active-low reset
//   bus        : slave side of pingpong_rally_ctrl_if (buttons in, display out)
module pingpong_rally_ctrl
  import pingpong_rally_ctrl_pkg::*;
#(
  parameter int TRACK_LEN = 16,
  parameter int STEP_DIV  = 4,
  parameter int WIN_SCORE = 11,
  parameter int SCORE_W   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  pingpong_rally_ctrl_if.slave  bus
);

  localparam int PW = $clog2(TRACK_LEN);

  state_e             state_q, state_d;
  player_e            server_q, server_d;
  player_e            who_q, who_d;
  player_e            winner_q, winner_d;
  logic [SCORE_W-1:0] score_a_q, score_a_d;
  logic [SCORE_W-1:0] score_b_q, score_b_d;
  logic               btn_a_q, btn_b_q;

  logic               press_a, press_b;
  logic [PW-1:0]      pos;
  logic               tick, at_a, at_b;
  logic               hit, up, dn, run, blank;
  logic [SCORE_W:0]   total;

  assign press_a = bus.btn_a & ~btn_a_q;
  assign press_b = bus.btn_b & ~btn_b_q;
  assign at_a    = (pos == '0);
  assign at_b    = (pos == PW'(TRACK_LEN - 1));
  assign total   = {1'b0, score_a_q} + {1'b0, score_b_q};

  pingpong_ball_track #(
    .TRACK_LEN (TRACK_LEN),
    .STEP_DIV  (STEP_DIV)
  ) u_track (
    .clk        (clk),
    .reset      (reset),
    .run_i      (run),
    .clr_i      (hit),
    .load_i     (state_d == ST_SERVE),
    .load_end_i (server_d == PL_B),
    .up_i       (up),
    .dn_i       (dn),
    .blank_i    (blank),
    .pos_o      (pos),
    .tick_o     (tick),
    .led_o      (bus.led_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_SERVE;
      server_q  <= PL_A;
      who_q     <= PL_A;
      winner_q  <= PL_A;
      score_a_q <= '0;
      score_b_q <= '0;
      btn_a_q   <= 1'b0;
      btn_b_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      server_q  <= server_d;
      who_q     <= who_d;
      winner_q  <= winner_d;
      score_a_q <= score_a_d;
      score_b_q <= score_b_d;
      btn_a_q   <= bus.btn_a;
      btn_b_q   <= bus.btn_b;
    end
  end

  always_comb begin
    state_d   = state_q;
    server_d  = server_q;
    who_d     = who_q;
    winner_d  = winner_q;
    score_a_d = score_a_q;
    score_b_d = score_b_q;
    hit       = 1'b0;
    up        = 1'b0;
    dn        = 1'b0;
    case (state_q)
      ST_SERVE: begin
        // Only the server's press counts; a simultaneous non-server press is dropped.
        if (server_q == PL_A && press_a)      state_d = ST_FLY_AB;
        else if (server_q == PL_B && press_b) state_d = ST_FLY_BA;
      end
      ST_FLY_AB: begin
        // A press in the window beats a same-cycle miss tick.
        if (press_b) begin
          if (at_b) begin
            state_d = ST_FLY_BA;
            hit     = 1'b1;
          end else begin
            state_d   = ST_POINT;
            who_d     = PL_A;
            score_a_d = score_a_q + 1'b1;
          end
        end else if (tick) begin
          if (at_b) begin
            state_d   = ST_POINT;
            who_d     = PL_A;
            score_a_d = score_a_q + 1'b1;
          end else begin
            up = 1'b1;
          end
        end
      end
      ST_FLY_BA: begin
        if (press_a) begin
          if (at_a) begin
            state_d = ST_FLY_AB;
            hit     = 1'b1;
          end else begin
            state_d   = ST_POINT;
            who_d     = PL_B;
            score_b_d = score_b_q + 1'b1;
          end
        end else if (tick) begin
          if (at_a) begin
            state_d   = ST_POINT;
            who_d     = PL_B;
            score_b_d = score_b_q + 1'b1;
          end else begin
            dn = 1'b1;
          end
        end
      end
      ST_POINT: begin
        // Scores already include this point; serve changes every two points.
        if (!total[0]) server_d = other(server_q);
        if (score_a_q == SCORE_W'(WIN_SCORE) || score_b_q == SCORE_W'(WIN_SCORE)) begin
          state_d  = ST_OVER;
          winner_d = (score_a_q == SCORE_W'(WIN_SCORE)) ? PL_A : PL_B;
        end else begin
          state_d = ST_SERVE;
        end
      end
      ST_OVER: begin
        if (press_a || press_b) begin
          state_d   = ST_SERVE;
          server_d  = PL_A;
          score_a_d = '0;
          score_b_d = '0;
        end
      end
      default: state_d = ST_SERVE;
    endcase
  end

  always_comb begin
    run           = (state_q == ST_FLY_AB) || (state_q == ST_FLY_BA);
    blank         = (state_q == ST_POINT) || (state_q == ST_OVER);
    bus.score_a   = score_a_q;
    bus.score_b   = score_b_q;
    bus.server    = server_q;
    bus.point_a   = (state_q == ST_POINT) && (who_q == PL_A);
    bus.point_b   = (state_q == ST_POINT) && (who_q == PL_B);
    bus.game_over = (state_q == ST_OVER);
    bus.winner    = winner_q;
  end

endmodule

// File: tb/tb_pingpong_rally_ctrl.sv
// Random-play bench for pingpong_rally_ctrl with a rule-level game model.
module tb_pingpong_rally_ctrl;
  localparam int L   = 16;
  localparam int DIV = 2;
  localparam int WIN = 11;
  localparam int SW  = 4;
  localparam int NCYC = 15000;
  localparam int RST_AT = 6000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pingpong_rally_ctrl_if #(.TRACK_LEN(L), .SCORE_W(SW)) bus();

  pingpong_rally_ctrl #(
    .TRACK_LEN (L),
    .STEP_DIV  (DIV),
    .WIN_SCORE (WIN),
    .SCORE_W   (SW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Game model: where the ball is, whose turn, who scored.
  typedef enum {M_WAIT, M_TO_B, M_TO_A, M_SCORED, M_DONE} phase_t;
  phase_t ph;
  int pos, cnt, sa, sb, srv, who, win, games;
  bit prev_a, prev_b;

  task automatic m_reset();
    ph = M_WAIT; pos = 0; cnt = 0; sa = 0; sb = 0; srv = 0; who = 0; win = 0;
    prev_a = 0; prev_b = 0;
  endtask

  task automatic m_score(input int p);
    if (p == 0) sa++; else sb++;
    who = p;
    ph = M_SCORED;
  endtask

  task automatic m_step(input bit ba, input bit bb);
    bit ea, eb, tick;
    ea = ba && !prev_a;
    eb = bb && !prev_b;
    prev_a = ba;
    prev_b = bb;
    tick = (cnt == DIV - 1);
    case (ph)
      M_WAIT: begin
        if (srv == 0 && ea) begin ph = M_TO_B; cnt = 0; end
        else if (srv == 1 && eb) begin ph = M_TO_A; cnt = 0; end
      end
      M_TO_B: begin
        if (eb) begin
          if (pos == L - 1) begin ph = M_TO_A; cnt = 0; end
          else m_score(0);
        end else if (tick && pos == L - 1) m_score(0);
        else begin
          if (tick) pos++;
          cnt = tick ? 0 : cnt + 1;
        end
      end
      M_TO_A: begin
        if (ea) begin
          if (pos == 0) begin ph = M_TO_B; cnt = 0; end
          else m_score(1);
        end else if (tick && pos == 0) m_score(1);
        else begin
          if (tick) pos--;
          cnt = tick ? 0 : cnt + 1;
        end
      end
      M_SCORED: begin
        if ((sa + sb) % 2 == 0) srv ^= 1;
        if (sa == WIN || sb == WIN) begin
          ph = M_DONE; win = (sb == WIN) ? 1 : 0; games++;
        end else begin
          ph = M_WAIT; pos = (srv == 1) ? L - 1 : 0;
        end
      end
      M_DONE: begin
        if (ea || eb) begin sa = 0; sb = 0; srv = 0; pos = 0; ph = M_WAIT; end
      end
      default: ph = M_WAIT;
    endcase
  endtask

  task automatic m_check();
    logic [L-1:0] one, eled;
    one = 1;
    eled = (ph == M_SCORED || ph == M_DONE) ? '1 : ~(one << (L - 1 - pos));
    chk("led_q", bus.led_q, eled);
    chk("score_a", bus.score_a, sa);
    chk("score_b", bus.score_b, sb);
    chk("server", bus.server, srv);
    chk("point_a", bus.point_a, (ph == M_SCORED && who == 0));
    chk("point_b", bus.point_b, (ph == M_SCORED && who == 1));
    chk("game_over", bus.game_over, (ph == M_DONE));
    if (ph == M_DONE) chk("winner", bus.winner, win);
  endtask

  // Players hit eagerly in their window, occasionally jump the gun.
  task automatic pick(output bit ba, output bit bb);
    ba = 0; bb = 0;
    case (ph)
      M_WAIT: begin
        ba = ($urandom_range(0, 3) == 0);
        bb = ($urandom_range(0, 3) == 0);
      end
      M_TO_B: begin
        bb = (pos == L - 1) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 79) == 0);
        ba = ($urandom_range(0, 15) == 0);
      end
      M_TO_A: begin
        ba = (pos == 0) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 79) == 0);
        bb = ($urandom_range(0, 15) == 0);
      end
      default: begin
        ba = ($urandom_range(0, 5) == 0);
        bb = ($urandom_range(0, 5) == 0);
      end
    endcase
  endtask

  initial begin
    bit ba, bb;
    games = 0;
    m_reset();
    bus.btn_a = 1'b1;  // held through reset release -> counts as a serve press
    bus.btn_b = 1'b0;
    #1 reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      m_check();
    end
    reset = 1'b1;
    @(posedge clk);
    m_step(bus.btn_a, bus.btn_b);

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      if (cyc == RST_AT) begin reset = 1'b0; m_reset(); end
      if (cyc == RST_AT + 4) reset = 1'b1;
      #1;
      m_check();
      pick(ba, bb);
      bus.btn_a = ba;
      bus.btn_b = bb;
      @(posedge clk);
      if (reset) m_step(ba, bb);
    end
    chk("games_done", (games > 0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
